// File: rtl/frame_decode.sv
// frame_decode: turns the PCD->PICC Modified Miller sequence stream
// (X/Y/Z/ERROR) into SOC, data-bit, EOC and error pulses.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   seq, seq_valid decoded sequence and its one-cycle strobe
//   idle           sequence_decode idle flag (aborts an open frame)
//   soc, eoc       start / end of communication pulses
//   data,          decoded bit, qualified by
//   data_valid     its one-cycle strobe
//   error          framing error pulse (frame aborted)
//   bit_count      data bits emitted in the current frame (saturating)

package frame_decode_pkg;
    typedef enum logic [1:0] {
        SEQ_X     = 2'd0,
        SEQ_Y     = 2'd1,
        SEQ_Z     = 2'd2,
        SEQ_ERROR = 2'd3
    } pcd_bit_seq_e;
endpackage

module frame_decode
    import frame_decode_pkg::*;
#(
    parameter int BIT_COUNT_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  pcd_bit_seq_e               seq,
    input  logic                       seq_valid,
    input  logic                       idle,
    output logic                       soc,
    output logic                       eoc,
    output logic                       data,
    output logic                       data_valid,
    output logic                       error,
    output logic [BIT_COUNT_WIDTH-1:0] bit_count
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DATA = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        P_SOC = 2'd0,
        P_X   = 2'd1,
        P_Y   = 2'd2,
        P_Z   = 2'd3
    } prev_e;

    localparam logic [BIT_COUNT_WIDTH-1:0] CNT_MAX = '1;

    state_e state_q, state_d;
    prev_e  prev_q, prev_d;
    logic   pend_q, pend_d;
    logic   pend_vld_q, pend_vld_d;

    logic soc_q, soc_d;
    logic eoc_q, eoc_d;
    logic data_q, data_d;
    logic dv_q, dv_d;
    logic err_q, err_d;
    logic [BIT_COUNT_WIDTH-1:0] cnt_q, cnt_d;

    // Action strobes shared by the next-state and output processes.
    logic go_soc, go_emit, go_eoc, go_err;

    // State register (includes frame context and registered outputs).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            prev_q     <= P_SOC;
            pend_q     <= 1'b0;
            pend_vld_q <= 1'b0;
            soc_q      <= 1'b0;
            eoc_q      <= 1'b0;
            data_q     <= 1'b0;
            dv_q       <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            soc_q      <= soc_d;
            eoc_q      <= eoc_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic. A decoded bit is held as "pending" until the
    // following sequence proves it is data and not the EOC "0".
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        go_soc     = 1'b0;
        go_emit    = 1'b0;
        go_eoc     = 1'b0;
        go_err     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (seq_valid && seq == SEQ_Z) begin
                    go_soc     = 1'b1;
                    state_d    = S_DATA;
                    prev_d     = P_SOC;
                    pend_vld_d = 1'b0;
                end
            end
            S_DATA: begin
                if (seq_valid) begin
                    unique case (seq)
                        SEQ_X: begin
                            go_emit    = pend_vld_q;
                            pend_d     = 1'b1;
                            pend_vld_d = 1'b1;
                            prev_d     = P_X;
                        end
                        SEQ_Z: begin
                            if (prev_q == P_X) begin
                                go_err = 1'b1;
                            end else begin
                                go_emit    = pend_vld_q;
                                pend_d     = 1'b0;
                                pend_vld_d = 1'b1;
                                prev_d     = P_Z;
                            end
                        end
                        SEQ_Y: begin
                            if (prev_q == P_X) begin
                                go_emit    = pend_vld_q;
                                pend_d     = 1'b0;
                                pend_vld_d = 1'b1;
                                prev_d     = P_Y;
                            end else if (prev_q == P_SOC) begin
                                go_err = 1'b1;
                            end else begin
                                go_eoc = 1'b1;
                            end
                        end
                        SEQ_ERROR: begin
                            go_err = 1'b1;
                        end
                    endcase
                end else if (idle) begin
                    go_err = 1'b1;
                end

                if (go_err || go_eoc) begin
                    state_d    = S_IDLE;
                    pend_vld_d = 1'b0;
                end
            end
        endcase
    end

    // Output logic: next values of the registered pulses and counter.
    always_comb begin
        soc_d  = go_soc;
        eoc_d  = go_eoc;
        err_d  = go_err;
        dv_d   = go_emit;
        data_d = go_emit ? pend_q : data_q;
        cnt_d  = cnt_q;
        if (go_soc) begin
            cnt_d = '0;
        end else if (go_emit && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + BIT_COUNT_WIDTH'(1);
        end
    end

    assign soc        = soc_q;
    assign eoc        = eoc_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign error      = err_q;
    assign bit_count  = cnt_q;

endmodule

// File: tb/tb_frame_decode.sv
// tb_frame_decode: directed checks of frame_decode framing, data bits,
// EOC disambiguation, error aborts, reset and counter saturation.

module tb_frame_decode;
    import frame_decode_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    pcd_bit_seq_e seq;
    logic         seq_valid;
    logic         idle;
    logic         soc, eoc, data, data_valid, error;
    logic [9:0]   bit_count;

    int checks = 0;
    int errors = 0;

    int          soc_n, eoc_n, err_n, dv_n;
    logic [31:0] bits;

    frame_decode #(.BIT_COUNT_WIDTH(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seq        (seq),
        .seq_valid  (seq_valid),
        .idle       (idle),
        .soc        (soc),
        .eoc        (eoc),
        .data       (data),
        .data_valid (data_valid),
        .error      (error),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor; also checks that at most one pulse is high.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("onehot", 32'($countones({soc, eoc, data_valid, error}) <= 1), 32'd1);
            if (soc) soc_n++;
            if (eoc) eoc_n++;
            if (error) err_n++;
            if (data_valid) begin
                if (dv_n < 32) bits[dv_n] = data;
                dv_n++;
            end
        end
    end

    task automatic clr();
        @(posedge clk);
        #1;
        soc_n = 0; eoc_n = 0; err_n = 0; dv_n = 0; bits = '0;
    endtask

    task automatic send(input pcd_bit_seq_e s);
        @(negedge clk);
        seq = s;
        seq_valid = 1'b1;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            seq_valid = 1'b0;
        end
    endtask

    task automatic chk_frame(input string tag, input int s, input int e,
                             input int r, input int n,
                             input logic [31:0] b, input int c);
        chk({tag, ".soc"}, 32'(soc_n), 32'(s));
        chk({tag, ".eoc"}, 32'(eoc_n), 32'(e));
        chk({tag, ".err"}, 32'(err_n), 32'(r));
        chk({tag, ".ndata"}, 32'(dv_n), 32'(n));
        chk({tag, ".bits"}, bits, b);
        chk({tag, ".cnt"}, 32'(bit_count), 32'(c));
    endtask

    initial begin
        rst_n = 1'b0;
        seq = SEQ_X;
        seq_valid = 1'b0;
        idle = 1'b0;
        soc_n = 0; eoc_n = 0; err_n = 0; dv_n = 0; bits = '0;
        #12;
        chk("rst.outs", 32'({soc, eoc, data, data_valid, error}), 32'd0);
        chk("rst.cnt", 32'(bit_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // REQA 0x26, 7 bits LSB first
        clr();
        send(SEQ_Z); send(SEQ_Z); send(SEQ_X); send(SEQ_X); send(SEQ_Y);
        send(SEQ_Z); send(SEQ_X); send(SEQ_Y); send(SEQ_Z); send(SEQ_Y);
        quiet(3);
        chk_frame("reqa", 1, 1, 0, 7, 32'h26, 7);

        // Last data bit 1
        clr();
        send(SEQ_Z); send(SEQ_X); send(SEQ_X); send(SEQ_Y); send(SEQ_Y);
        quiet(3);
        chk_frame("last1", 1, 1, 0, 2, 32'h3, 2);

        // Empty frame
        clr();
        send(SEQ_Z); send(SEQ_Z); send(SEQ_Y);
        quiet(3);
        chk_frame("empty", 1, 1, 0, 0, 32'h0, 0);

        // ERROR mid-frame discards the pending 1
        clr();
        send(SEQ_Z); send(SEQ_X); send(SEQ_ERROR);
        quiet(3);
        chk_frame("errmid", 1, 0, 1, 0, 32'h0, 0);
        clr();
        send(SEQ_Z); send(SEQ_X); send(SEQ_Y); send(SEQ_Y);
        quiet(3);
        chk_frame("after_err", 1, 1, 0, 1, 32'h1, 1);

        // Invalid start: first 0 must be Z
        clr();
        send(SEQ_Z); send(SEQ_Y);
        quiet(3);
        chk_frame("badstart", 1, 0, 1, 0, 32'h0, 0);

        // Leading X/Y/ERROR while idle produce nothing
        clr();
        send(SEQ_X); send(SEQ_Y); send(SEQ_ERROR);
        quiet(3);
        chk_frame("idle_ign", 0, 0, 0, 0, 32'h0, 0);

        // Z directly after X is a framing error
        clr();
        send(SEQ_Z); send(SEQ_X); send(SEQ_Z);
        quiet(3);
        chk_frame("xz", 1, 0, 1, 0, 32'h0, 0);

        // idle asserted inside a frame aborts it
        clr();
        send(SEQ_Z); send(SEQ_X);
        quiet(1);
        idle = 1'b1;
        @(negedge clk);
        idle = 1'b0;
        quiet(2);
        chk_frame("idle_abort", 1, 0, 1, 0, 32'h0, 0);

        // Back-to-back frames, next Z right after the EOC Y
        clr();
        send(SEQ_Z); send(SEQ_Z); send(SEQ_Y);
        send(SEQ_Z); send(SEQ_X); send(SEQ_X); send(SEQ_Y); send(SEQ_Y);
        quiet(3);
        chk_frame("b2b", 2, 2, 0, 2, 32'h3, 2);

        // Reset mid-frame after 5 bits
        clr();
        send(SEQ_Z);
        for (int i = 0; i < 6; i++) send(SEQ_X);
        quiet(2);
        chk("pre_rst.cnt", 32'(bit_count), 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.outs", 32'({soc, eoc, data, data_valid, error}), 32'd0);
        chk("midrst.cnt", 32'(bit_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        send(SEQ_Z); send(SEQ_X); send(SEQ_Y); send(SEQ_Y);
        quiet(3);
        chk_frame("post_rst", 1, 1, 0, 1, 32'h1, 1);

        // Saturation: 1030 bits emitted, counter stops at 1023
        clr();
        send(SEQ_Z);
        for (int i = 0; i < 1030; i++) send(SEQ_X);
        send(SEQ_Y); send(SEQ_Y);
        quiet(3);
        chk("sat.cnt", 32'(bit_count), 32'd1023);
        chk("sat.ndata", 32'(dv_n), 32'd1030);
        chk("sat.eoc", 32'(eoc_n), 32'd1);
        chk("sat.err", 32'(err_n), 32'd0);

        // Counter holds after EOC until the next SOC clears it
        quiet(4);
        chk("hold.cnt", 32'(bit_count), 32'd1023);
        clr();
        send(SEQ_Z);
        quiet(2);
        chk("soc_clr.cnt", 32'(bit_count), 32'd0);
        chk("soc_clr.soc", 32'(soc_n), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
